alu_mul_sequencer: RTL and testbench

//  Owns the shared 64-bit LEGv8 ALU; multiplexes it between the CPU datapath and an internal shift-add multiply sequencer.

---
 rtl/alu_mul_sequencer_pkg.sv | 21 ++
 rtl/alu_mul_sequencer_port_mux.sv | 22 ++
 rtl/alu_mul_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: ALU function codes, status bit indices and sequencer state encoding
package alu_mul_sequencer_pkg;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;
  localparam int STATUS_Z = 0;
  localparam int STATUS_N = 1;
  localparam int STATUS_C = 2;
  localparam int STATUS_V = 3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_ADD,
    ST_SHL,
    ST_SHR,
    ST_DONE
  } state_t;
endpackage

// File: rtl/alu_mul_sequencer_port_mux.sv
// alu_mul_sequencer_port_mux: 2:1 select of the ALU {A,B,FS,C0} bundle
//   sel=0 -> cpu_*, sel=1 -> seq_*; result on alu_*
module alu_mul_sequencer_port_mux #(
  parameter int WIDTH = 64
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] cpu_a,
  input  logic [WIDTH-1:0] cpu_b,
  input  logic [4:0]       cpu_fs,
  input  logic             cpu_c0,
  input  logic [WIDTH-1:0] seq_a,
  input  logic [WIDTH-1:0] seq_b,
  input  logic [4:0]       seq_fs,
  input  logic             seq_c0,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_fs,
  output logic             alu_c0
);
  assign {alu_a, alu_b, alu_fs, alu_c0} = sel ? {seq_a, seq_b, seq_fs, seq_c0}
                                              : {cpu_a, cpu_b, cpu_fs, cpu_c0};
endmodule

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shares one LEGv8 ALU between the CPU and a shift-add multiplier
//   clock/reset_n      : rising-edge clock, async active-low reset
//   cpu_A/B/FS/C0      : CPU ALU request, passed through while idle
//   cpu_stall          : high while the multiplier owns the ALU
//   mul_start/a/b      : multiply request, accepted only when idle
//   mul_done/result/carry : one-cycle done pulse, low product, sticky add carry
//   alu_A/B/FS/C0      : drive the shared ALU
//   alu_F/alu_status   : ALU result and {V,C,N,Z}
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cpu_A,
  input  logic [WIDTH-1:0] cpu_B,
  input  logic [4:0]       cpu_FS,
  input  logic             cpu_C0,
  output logic             cpu_stall,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  output logic             mul_done,
  output logic [WIDTH-1:0] mul_result,
  output logic             mul_carry,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status
);
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, mcand, mplier, seq_a, seq_b;
  logic [CNT_W-1:0] cnt;
  logic [4:0] seq_fs;
  logic carry;
  logic unused_status;
  assign unused_status = ^{alu_status[STATUS_V], alu_status[STATUS_N]};
  assign cpu_stall = state != ST_IDLE;
  always_comb begin
    state_nx = state;
    seq_a = '0;
    seq_b = '0;
    seq_fs = FS_ADD;
    unique case (state)
      ST_IDLE: state_nx = mul_start ? (mul_b == '0 ? ST_DONE : ST_CHK) : ST_IDLE;
      ST_CHK:  state_nx = mplier[0] ? ST_ADD : ST_SHL;
      ST_ADD: begin
        seq_a = acc;
        seq_b = mcand;
        state_nx = ST_SHL;
      end
      ST_SHL: begin
        seq_a = mcand;
        seq_b = WIDTH'(1);
        seq_fs = FS_LSL;
        state_nx = ST_SHR;
      end
      ST_SHR: begin
        seq_a = mplier;
        seq_b = WIDTH'(1);
        seq_fs = FS_LSR;
        // Z after the shift means no multiplier bits remain
        state_nx = (alu_status[STATUS_Z] || cnt == CNT_W'(WIDTH-1)) ? ST_DONE : ST_CHK;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end
  alu_mul_sequencer_port_mux #(.WIDTH(WIDTH)) u_mux (
    .sel(cpu_stall),
    .cpu_a(cpu_A),
    .cpu_b(cpu_B),
    .cpu_fs(cpu_FS),
    .cpu_c0(cpu_C0),
    .seq_a(seq_a),
    .seq_b(seq_b),
    .seq_fs(seq_fs),
    .seq_c0(1'b0),
    .alu_a(alu_A),
    .alu_b(alu_B),
    .alu_fs(alu_FS),
    .alu_c0(alu_C0)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      carry <= 1'b0;
      mul_result <= '0;
      mul_carry <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      state <= state_nx;
      mul_done <= state == ST_DONE;
      if (state == ST_IDLE && mul_start) begin
        mcand <= mul_a;
        mplier <= mul_b;
        acc <= '0;
        cnt <= '0;
        carry <= 1'b0;
      end
      if (state == ST_ADD) begin
        acc <= alu_F;
        carry <= carry | alu_status[STATUS_C];
      end
      if (state == ST_SHL) mcand <= alu_F;
      if (state == ST_SHR) begin
        mplier <= alu_F;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_DONE) begin
        mul_result <= acc;
        mul_carry <= carry;
      end
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: self-checking bench with a behavioural ALU behind the sequencer
module tb_alu_mul_sequencer;
  localparam logic [4:0] F_AND = 5'b00000;
  localparam logic [4:0] F_OR  = 5'b00100;
  localparam logic [4:0] F_ADD = 5'b01000;
  localparam logic [4:0] F_XOR = 5'b01100;
  localparam logic [4:0] F_LSL = 5'b10000;
  localparam logic [4:0] F_LSR = 5'b10100;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [63:0] cpu_A = '0, cpu_B = '0, mul_a = '0, mul_b = '0;
  logic [4:0] cpu_FS = '0;
  logic cpu_C0 = 1'b0, mul_start = 1'b0;
  logic cpu_stall, mul_done, mul_carry, alu_C0;
  logic [63:0] mul_result, alu_A, alu_B, alu_F;
  logic [4:0] alu_FS;
  logic [3:0] alu_status;
  logic alu_c;
  int n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  alu_mul_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_A(cpu_A), .cpu_B(cpu_B), .cpu_FS(cpu_FS), .cpu_C0(cpu_C0),
    .cpu_stall(cpu_stall),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .mul_carry(mul_carry),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_C0(alu_C0),
    .alu_F(alu_F), .alu_status(alu_status)
  );

  always_comb begin
    alu_c = 1'b0;
    alu_F = '0;
    case (alu_FS)
      F_ADD: {alu_c, alu_F} = {1'b0, alu_A} + {1'b0, alu_B} + {64'd0, alu_C0};
      F_LSL: alu_F = alu_A << alu_B[5:0];
      F_LSR: alu_F = alu_A >> alu_B[5:0];
      F_AND: alu_F = alu_A & alu_B;
      F_OR:  alu_F = alu_A | alu_B;
      F_XOR: alu_F = alu_A ^ alu_B;
      default: alu_F = '0;
    endcase
    alu_status = {(alu_FS == F_ADD) && (alu_A[63] == alu_B[63]) && (alu_F[63] != alu_A[63]),
                  alu_c, alu_F[63], alu_F == '0};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Product is plain a*b; carry is whether any partial-product accumulation overflowed;
  // latency is 2 plus 3 cycles per multiplier bit up to the top set bit, plus 1 per set bit.
  task automatic ref_mul(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] p, output logic c, output int lat);
    logic [64:0] s;
    logic [63:0] sum = '0;
    int msb = -1;
    p = a * b;
    c = 1'b0;
    lat = 2;
    for (int i = 0; i < 64; i++) if (b[i]) msb = i;
    for (int i = 0; i <= msb; i++) begin
      lat += b[i] ? 4 : 3;
      if (b[i]) begin
        s = {1'b0, sum} + {1'b0, a << i};
        sum = s[63:0];
        c |= s[64];
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input bit tog,
                        output logic [63:0] res, output logic car, output int lat,
                        output int pulses, output bit stall_ok, output bit hold_ok);
    logic [63:0] prev = mul_result;
    res = 'x;
    car = 1'bx;
    lat = 0;
    pulses = 0;
    stall_ok = 1;
    hold_ok = 1;
    mul_a = a;
    mul_b = b;
    mul_start = 1'b1;
    @(posedge clock);
    #1 mul_start = 1'b0;
    for (int i = 1; i <= 400 && lat == 0; i++) begin
      if (mul_done) begin
        lat = i;
        res = mul_result;
        car = mul_carry;
        pulses = 1;
        if (cpu_stall) stall_ok = 0;
      end else begin
        if (!cpu_stall) stall_ok = 0;
        if (mul_result !== prev) hold_ok = 0;
        if (tog) begin
          cpu_A = {$urandom, $urandom};
          cpu_B = {$urandom, $urandom};
          cpu_FS = 5'($urandom);
          cpu_C0 = 1'($urandom);
        end
        @(posedge clock);
        #1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 if (mul_done) pulses++;
    end
  endtask

  task automatic mul_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input bit tog, output logic [63:0] res, output logic car,
                           output int lat);
    logic [63:0] ep;
    logic ec;
    int el, pulses;
    bit s_ok, h_ok;
    do_mul(a, b, tog, res, car, lat, pulses, s_ok, h_ok);
    ref_mul(a, b, ep, ec, el);
    chk({tag, " result"}, res, ep);
    chk({tag, " carry"}, 64'(car), 64'(ec));
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " done_pulses"}, 64'(pulses), 64'd1);
    chk({tag, " stall_while_busy"}, 64'(s_ok), 64'd1);
    chk({tag, " result_held"}, 64'(h_ok), 64'd1);
  endtask

  typedef struct {
    logic [4:0]  fs;
    logic [63:0] a, b;
    logic        c0;
    logic [63:0] f;
  } pt_t;

  initial begin
    pt_t pt[8];
    logic [63:0] r;
    logic c;
    int lat, cnt;
    pt[0] = '{F_ADD, 64'd7, 64'd9, 1'b0, 64'd16};
    pt[1] = '{F_ADD, 64'd5, 64'd6, 1'b1, 64'd12};
    pt[2] = '{F_ADD, ONES, 64'd1, 1'b0, 64'd0};
    pt[3] = '{F_AND, 64'hF0F0, 64'hFF00, 1'b0, 64'hF000};
    pt[4] = '{F_OR, 64'hF0F0, 64'h0F00, 1'b0, 64'hFFF0};
    pt[5] = '{F_XOR, 64'hFF, 64'h0F, 1'b0, 64'hF0};
    pt[6] = '{F_LSL, 64'd1, 64'd4, 1'b0, 64'd16};
    pt[7] = '{F_LSR, 64'h100, 64'd8, 1'b0, 64'd1};

    @(posedge clock);
    #1;
    chk("reset stall", 64'(cpu_stall), 64'd0);
    chk("reset done", 64'(mul_done), 64'd0);
    chk("reset result", mul_result, 64'd0);
    chk("reset carry", 64'(mul_carry), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (pt[i]) begin
      cpu_FS = pt[i].fs;
      cpu_A = pt[i].a;
      cpu_B = pt[i].b;
      cpu_C0 = pt[i].c0;
      #1;
      chk($sformatf("pass%0d alu_F", i), alu_F, pt[i].f);
      chk($sformatf("pass%0d alu_A", i), alu_A, pt[i].a);
      chk($sformatf("pass%0d alu_FS", i), 64'(alu_FS), 64'(pt[i].fs));
      chk($sformatf("pass%0d alu_C0", i), 64'(alu_C0), 64'(pt[i].c0));
      chk($sformatf("pass%0d stall", i), 64'(cpu_stall), 64'd0);
    end
    @(posedge clock);
    #1;

    mul_check("t1", 64'd3, 64'd5, 0, r, c, lat);
    chk("t1 result const", r, 64'd15);
    chk("t1 latency const", 64'(lat), 64'd13);
    mul_check("t2", 64'hDEAD, 64'd0, 0, r, c, lat);
    chk("t2 latency const", 64'(lat), 64'd2);
    mul_check("t3", 64'd1, 64'h8000_0000_0000_0000, 0, r, c, lat);
    chk("t3 result const", r, 64'h8000_0000_0000_0000);
    chk("t3 latency const", 64'(lat), 64'd195);
    mul_check("t4", ONES, ONES, 1, r, c, lat);
    chk("t4 result const", r, 64'd1);
    chk("t4 carry const", 64'(c), 64'd1);
    chk("t4 latency const", 64'(lat), 64'd258);

    mul_a = 64'h1234_5678;
    mul_b = ONES;
    mul_start = 1'b1;
    @(posedge clock);
    #1 mul_start = 1'b0;
    repeat (40) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort stall", 64'(cpu_stall), 64'd0);
    chk("abort result", mul_result, 64'd0);
    chk("abort carry", 64'(mul_carry), 64'd0);
    chk("abort done", 64'(mul_done), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1 if (mul_done) cnt++;
    end
    chk("abort no_done", 64'(cnt), 64'd0);

    mul_a = 64'd3;
    mul_b = 64'hFF;
    mul_start = 1'b1;
    @(posedge clock);
    #1 mul_start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    mul_a = 64'd7;
    mul_b = 64'd2;
    mul_start = 1'b1;
    @(posedge clock);
    #1 mul_start = 1'b0;
    cnt = 0;
    r = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1 if (mul_done) begin
        cnt++;
        r = mul_result;
      end
    end
    chk("busy_start pulses", 64'(cnt), 64'd1);
    chk("busy_start result", r, 64'd765);

    for (int i = 0; i < 16; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      mul_check($sformatf("rand%0d", i), a, b, i[0], r, c, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
